// File: rtl/comps_pkg.sv
// Shared types and widths for the comparator-capture front end.
// No logic; constants and the capture FSM state type only.
// Imported by comps_capture.
package comps_pkg;

    localparam int N_COMPS = 5;
    localparam int N_RAW   = N_COMPS + 2;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } cap_state_t;

endpackage

// File: rtl/comps_capture_debounce_cell.sv
// Two-flop synchroniser plus run-length debounce for one raw async level.
// Latency: 2 sync edges + DEBOUNCE_CYCLES edges of sustained mismatch.
// No backpressure; a mismatch shorter than DEBOUNCE_CYCLES is discarded.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise, then accept the new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/comps_capture.sv
// Debounced switch capture feeding the 7-segment decoder: live or frozen snapshot.
// Latency: DEBOUNCE_CYCLES+3 edges from a held raw input to comps/locked.
// No backpressure; outputs are registered and held for the combinational decoder.
module comps_capture
    import comps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_COMPS-1:0] sw_in,
    input  logic               btn_confirm,
    input  logic               btn_clear,
    output logic [N_COMPS-1:0] comps,
    output logic               locked,
    output logic               changed
);

    logic [N_RAW-1:0]   w_raw;
    logic [N_RAW-1:0]   w_stable;
    logic [N_COMPS-1:0] w_stable_sw;
    logic               w_confirm_p;
    logic               w_clear_p;
    logic               w_load;
    logic [N_COMPS-1:0] w_comps_nxt;

    cap_state_t         r_state;
    logic [N_COMPS-1:0] r_comps;
    logic               r_locked;
    logic               r_changed;
    logic               r_confirm_prev;
    logic               r_clear_prev;

    assign w_raw = {btn_clear, btn_confirm, sw_in};

    for (genvar g = 0; g < N_RAW; g++) begin : g_db
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (w_raw[g]),
            .stable(w_stable[g])
        );
    end

    assign w_stable_sw = w_stable[N_COMPS-1:0];
    assign w_confirm_p = w_stable[N_COMPS]   & ~r_confirm_prev;
    assign w_clear_p   = w_stable[N_COMPS+1] & ~r_clear_prev;

    // While open, or on the clear edge out of lock, comps tracks the debounced switches.
    assign w_load      = (r_state == ST_OPEN) | w_clear_p;
    assign w_comps_nxt = w_load ? w_stable_sw : r_comps;

    // Capture FSM with registered comps/locked/changed; clear beats a simultaneous confirm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_OPEN;
            r_comps        <= '0;
            r_locked       <= 1'b0;
            r_changed      <= 1'b0;
            r_confirm_prev <= 1'b0;
            r_clear_prev   <= 1'b0;
        end else begin
            r_confirm_prev <= w_stable[N_COMPS];
            r_clear_prev   <= w_stable[N_COMPS+1];
            r_comps        <= w_comps_nxt;
            r_changed      <= (w_comps_nxt != r_comps);
            case (r_state)
                ST_OPEN: begin
                    if (w_confirm_p && !w_clear_p) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_clear_p) begin
                        r_state  <= ST_OPEN;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_OPEN;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign comps   = r_comps;
    assign locked  = r_locked;
    assign changed = r_changed;

endmodule

// File: tb/tb_comps_capture.sv
// Randomised plus directed stimulus against a behavioural model of comps_capture.
// Expected outputs are queued per edge; a negedge monitor pops and compares.
// Runs a fixed number of cycles and always terminates.
module tb_comps_capture;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sw_in;
    logic       btn_confirm;
    logic       btn_clear;
    logic [4:0] comps;
    logic       locked;
    logic       changed;

    always #5 clk = ~clk;

    comps_capture #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .btn_confirm(btn_confirm),
        .btn_clear  (btn_clear),
        .comps      (comps),
        .locked     (locked),
        .changed    (changed)
    );

    typedef struct packed {
        logic [4:0] comps;
        logic       locked;
        logic       changed;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: raw history, debounced levels, run lengths, capture state.
    logic [6:0] raw_hist[$];
    logic [6:0] m_stable;
    int         m_run[7];
    logic [6:0] m_prev;
    logic [4:0] m_comps;
    logic       m_locked;
    logic       m_changed;

    task automatic model_edge(input logic [4:0] sw, input logic c, input logic k, input logic r);
        logic [6:0] sync_v;
        logic [6:0] st_old;
        logic       cp;
        logic       kp;
        logic [4:0] nc;
        if (!r) begin
            raw_hist.delete();
            m_stable  = '0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
            m_prev    = '0;
            m_comps   = '0;
            m_locked  = 1'b0;
            m_changed = 1'b0;
        end else begin
            // The level seen by the debouncer is the raw value from two edges back.
            sync_v = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 7'd0;
            raw_hist.push_back({k, c, sw});
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            st_old = m_stable;
            cp     = st_old[5] & ~m_prev[5];
            kp     = st_old[6] & ~m_prev[6];
            m_prev = st_old;
            nc     = (!m_locked || kp) ? st_old[4:0] : m_comps;
            m_changed = (nc != m_comps);
            m_comps   = nc;
            if (m_locked && kp)                m_locked = 1'b0;
            else if (!m_locked && cp && !kp)   m_locked = 1'b1;
            for (int i = 0; i < 7; i++) begin
                if (sync_v[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_stable[i] = sync_v[i];
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        expq.push_back({m_comps, m_locked, m_changed});
    endtask

    task automatic step(input logic [4:0] sw, input logic c, input logic k, input logic r);
        sw_in       = sw;
        btn_confirm = c;
        btn_clear   = k;
        rst_n       = r;
        @(posedge clk);
        model_edge(sw, c, k, r);
        #1;
    endtask

    task automatic hold(input logic [4:0] sw, input logic c, input logic k, input logic r, input int n);
        for (int i = 0; i < n; i++) step(sw, c, k, r);
    endtask

    function automatic void chk(input string nm, input logic [4:0] got, input logic [4:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, want, $time);
        end
    endfunction

    exp_t e;

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("comps",   comps,          e.comps);
            chk("locked",  {4'd0, locked},  {4'd0, e.locked});
            chk("changed", {4'd0, changed}, {4'd0, e.changed});
        end
    end

    initial begin
        logic [4:0] rs;
        logic       rc;
        logic       rk;
        logic       rr;
        int         len;

        // Reset with switches already set, then release.
        hold(5'b10101, 1'b0, 1'b0, 1'b0, 3);
        hold(5'b10101, 1'b0, 1'b0, 1'b1, 12);

        // Glitch reject (3 cycles) and accept (4 cycles).
        hold(5'b00000, 1'b0, 1'b0, 1'b1, 12);
        hold(5'b00001, 1'b0, 1'b0, 1'b1, 3);
        hold(5'b00000, 1'b0, 1'b0, 1'b1, 12);
        hold(5'b00001, 1'b0, 1'b0, 1'b1, 4);
        hold(5'b00000, 1'b0, 1'b0, 1'b1, 12);

        // Lock, then switch changes are ignored.
        hold(5'b00111, 1'b0, 1'b0, 1'b1, 10);
        hold(5'b00111, 1'b1, 1'b0, 1'b1, 10);
        hold(5'b11111, 1'b0, 1'b0, 1'b1, 20);

        // Clear, then a long confirm hold locks exactly once.
        hold(5'b11111, 1'b0, 1'b1, 1'b1, 10);
        hold(5'b11111, 1'b0, 1'b0, 1'b1, 8);
        hold(5'b11111, 1'b1, 1'b0, 1'b1, 20);
        hold(5'b01100, 1'b0, 1'b0, 1'b1, 10);

        // Simultaneous confirm and clear, from locked and from open.
        hold(5'b01100, 1'b1, 1'b1, 1'b1, 10);
        hold(5'b01100, 1'b0, 1'b0, 1'b1, 10);
        hold(5'b00110, 1'b1, 1'b1, 1'b1, 10);
        hold(5'b00110, 1'b0, 1'b0, 1'b1, 10);

        // Reset mid-lock, with confirm held through the reset.
        hold(5'b01010, 1'b1, 1'b0, 1'b1, 12);
        hold(5'b01010, 1'b1, 1'b0, 1'b0, 1);
        hold(5'b01010, 1'b1, 1'b0, 1'b1, 12);
        hold(5'b01010, 1'b0, 1'b1, 1'b1, 10);
        hold(5'b01010, 1'b0, 1'b0, 1'b1, 6);

        // Random segments of varying length, including sub-debounce glitches.
        rs = 5'b0;
        rc = 1'b0;
        rk = 1'b0;
        for (int s = 0; s < 500; s++) begin
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 1) == 0) rs = 5'($urandom_range(0, 31));
            rc = ($urandom_range(0, 3) == 0);
            rk = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 80) != 0);
            if (!rr) len = $urandom_range(1, 2);
            hold(rs, rc, rk, rr, len);
        end
        hold(rs, 1'b0, 1'b0, 1'b1, 4);

        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
